// File: rtl/mmio_lcd_timing_m_pkg.sv
// Shared LCD timing definitions: PPU mode encoding, LCD register addresses,
// scanline timing constants and the dot/line to mode decode.
package mmio_lcd_timing_m_pkg;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAW     = 2'd3
  } ppu_mode_e;

  localparam logic [7:0] ADDR_LCDC = 8'h40;
  localparam logic [7:0] ADDR_STAT = 8'h41;
  localparam logic [7:0] ADDR_LY   = 8'h44;
  localparam logic [7:0] ADDR_LYC  = 8'h45;

  localparam int unsigned DOTS_PER_LINE   = 456;
  localparam int unsigned LINES_PER_FRAME = 154;
  localparam int unsigned VISIBLE_LINES   = 144;
  localparam int unsigned OAM_DOTS        = 80;
  localparam int unsigned DRAW_DOTS       = 172;

  localparam logic [7:0] LCDC_RESET = 8'h91;

  function automatic ppu_mode_e decode_mode(input logic [8:0] dot, input logic [7:0] ly);
    if (ly >= 8'(VISIBLE_LINES))
      return VBLANK;
    else if (dot < 9'(OAM_DOTS))
      return OAM_SCAN;
    else if (dot < 9'(OAM_DOTS + DRAW_DOTS))
      return DRAW;
    else
      return HBLANK;
  endfunction

endpackage

// File: rtl/mmio_lcd_timing_m_dot_counter.sv
// Dot/line counter: counts dots within a line and lines within a frame while
// running, and holds both at zero otherwise.
module lcd_dot_counter_m
  import mmio_lcd_timing_m_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [8:0] dot,
  output logic [7:0] ly,
  output logic [8:0] dot_next,
  output logic [7:0] ly_next,
  output logic       vblank_start
);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;

  always_comb begin
    dot_d = dot_q;
    ly_d  = ly_q;
    if (!run) begin
      dot_d = '0;
      ly_d  = '0;
    end else if (dot_q == 9'(DOTS_PER_LINE - 1)) begin
      dot_d = '0;
      ly_d  = (ly_q == 8'(LINES_PER_FRAME - 1)) ? '0 : ly_q + 8'd1;
    end else begin
      dot_d = dot_q + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_q <= '0;
      ly_q  <= '0;
    end else begin
      dot_q <= dot_d;
      ly_q  <= ly_d;
    end
  end

  assign dot          = dot_q;
  assign ly           = ly_q;
  assign dot_next     = dot_d;
  assign ly_next      = ly_d;
  assign vblank_start = run && (dot_q == 9'(DOTS_PER_LINE - 1)) &&
                        (ly_q == 8'(VISIBLE_LINES - 1));

endmodule

// File: rtl/mmio_lcd_timing_m.sv
// LCD timing controller: LCDC/STAT/LY/LYC registers, PPU mode sequencing and
// the vblank / lcd_stat interrupt request pulses.
module mmio_lcd_timing_m
  import mmio_lcd_timing_m_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       vblank_irq,
  output logic       lcd_stat_irq,
  output logic       lcd_on,
  output logic [1:0] ppu_mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic [7:0] lcdc
);

  logic [7:0] lcdc_q, lcdc_d;
  logic [3:0] stat_en_q, stat_en_d;
  logic [7:0] lyc_q, lyc_d;
  ppu_mode_e  mode_q, mode_d;
  logic       lyc_eq_q, lyc_eq_d;
  logic       stat_line_q, stat_line_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic       lcd_stat_irq_q, lcd_stat_irq_d;
  logic [7:0] rdata_q, rdata_d;

  logic       run;
  logic [8:0] dot_next;
  logic [7:0] ly_next;
  logic       vblank_start;

  always_comb begin
    lcdc_d    = lcdc_q;
    stat_en_d = stat_en_q;
    lyc_d     = lyc_q;
    if (sel && we) begin
      case (addr)
        ADDR_LCDC: lcdc_d    = wdata;
        ADDR_STAT: stat_en_d = wdata[6:3];
        ADDR_LYC:  lyc_d     = wdata;
        default:   ;
      endcase
    end
  end

  // Counting stops on the same edge that LCDC.7 is cleared, and the first
  // enabled cycle starts from dot 0, so disabling at vblank entry drops the pulse.
  always_comb begin
    run = lcdc_q[7] & lcdc_d[7];
  end

  lcd_dot_counter_m u_dot_counter (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .dot          (dot),
    .ly           (ly),
    .dot_next     (dot_next),
    .ly_next      (ly_next),
    .vblank_start (vblank_start)
  );

  // Mode and lyc_eq come from the next dot/ly so every STAT source switches on
  // the same edge; a hand-over between sources then never shows a low gap.
  always_comb begin
    mode_d         = lcdc_d[7] ? decode_mode(dot_next, ly_next) : HBLANK;
    lyc_eq_d       = (ly_next == lyc_d);
    stat_line_d    = (stat_en_d[3] & lyc_eq_d) |
                     (stat_en_d[2] & (mode_d == OAM_SCAN)) |
                     (stat_en_d[1] & (mode_d == VBLANK)) |
                     (stat_en_d[0] & (mode_d == HBLANK));
    lcd_stat_irq_d = lcdc_d[7] & stat_line_d & ~stat_line_q;
    vblank_irq_d   = vblank_start;

    rdata_d = '0;
    if (sel) begin
      case (addr)
        ADDR_LCDC: rdata_d = lcdc_q;
        ADDR_STAT: rdata_d = {1'b1, stat_en_q, lyc_eq_q, mode_q};
        ADDR_LY:   rdata_d = ly;
        ADDR_LYC:  rdata_d = lyc_q;
        default:   rdata_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcdc_q         <= LCDC_RESET;
      stat_en_q      <= '0;
      lyc_q          <= '0;
      mode_q         <= HBLANK;
      lyc_eq_q       <= 1'b0;
      stat_line_q    <= 1'b0;
      vblank_irq_q   <= 1'b0;
      lcd_stat_irq_q <= 1'b0;
      rdata_q        <= '0;
    end else begin
      lcdc_q         <= lcdc_d;
      stat_en_q      <= stat_en_d;
      lyc_q          <= lyc_d;
      mode_q         <= mode_d;
      lyc_eq_q       <= lyc_eq_d;
      stat_line_q    <= stat_line_d;
      vblank_irq_q   <= vblank_irq_d;
      lcd_stat_irq_q <= lcd_stat_irq_d;
      rdata_q        <= rdata_d;
    end
  end

  assign rdata        = rdata_q;
  assign vblank_irq   = vblank_irq_q;
  assign lcd_stat_irq = lcd_stat_irq_q;
  assign lcd_on       = lcdc_q[7];
  assign ppu_mode     = mode_q;
  assign lcdc         = lcdc_q;

endmodule

// File: tb/tb_mmio_lcd_timing_m.sv
// Directed bench for mmio_lcd_timing_m: register access, frame timing, mode
// sequence, STAT interrupts and LCD disable/enable.
module tb_mmio_lcd_timing_m;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] addr = '0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       vblank_irq, lcd_stat_irq, lcd_on;
  logic [1:0] ppu_mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [7:0] lcdc;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  int unsigned cyc     = 0;
  int unsigned base    = 0;
  int unsigned vb_cnt  = 0;
  int unsigned vb_last = 0;
  int unsigned st_cnt  = 0;
  int unsigned v0, s0, s1, vs, ss;

  logic [7:0] exp_q[$];

  mmio_lcd_timing_m dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .addr         (addr),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata),
    .vblank_irq   (vblank_irq),
    .lcd_stat_irq (lcd_stat_irq),
    .lcd_on       (lcd_on),
    .ppu_mode     (ppu_mode),
    .ly           (ly),
    .dot          (dot),
    .lcdc         (lcdc)
  );

  always #5 clk = ~clk;

  // Pulse monitor; cyc value recorded is the one seen by the stimulus at the
  // falling edge where the pulse was visible.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vblank_irq) begin
      vb_cnt  <= vb_cnt + 1;
      vb_last <= cyc;
    end
    if (lcd_stat_irq)
      st_cnt <= st_cnt + 1;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    sel = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    sel = 1'b0;
    e = exp_q.pop_front();
    chk(tag, rdata, e);
  endtask

  task automatic goto(input int unsigned l, input int unsigned d);
    int unsigned t;
    t = base + l * 456 + d;
    if (t > cyc)
      repeat (t - cyc) @(negedge clk);
    else if (t < cyc)
      chk("schedule", cyc, t);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);

    // asynchronous reset mid-line, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_dot", dot, 0);
    chk("rst_ly", ly, 0);
    chk("rst_mode", ppu_mode, 0);
    chk("rst_lcdc", lcdc, 8'h91);
    chk("rst_irqs", {vblank_irq, lcd_stat_irq}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    rd(8'h41, 8'h80, "rst_stat_rd");
    base = cyc - 1;
    rd(8'h44, 8'h00, "rst_ly_rd");

    // register access on line 3
    goto(3, 10);
    wr(8'h41, 8'hFF);
    rd(8'h41, 8'hFA, "stat_mask");
    rd(8'h44, 8'h03, "ly_rd");
    wr(8'h44, 8'h55);
    rd(8'h44, 8'h03, "ly_ro");
    rd(8'h40, 8'h91, "lcdc_rd");
    rd(8'h45, 8'h00, "lyc_rd");
    rd(8'h42, 8'hFF, "unmapped_rd");

    // LCD off mid-frame with every STAT source enabled
    wr(8'h40, 8'h11);
    chk("off_dot", dot, 0);
    chk("off_ly", ly, 0);
    chk("off_mode", ppu_mode, 0);
    chk("off_lcd_on", lcd_on, 0);
    vs = vb_cnt; ss = st_cnt;
    wr(8'h45, 8'h07);
    wr(8'h45, 8'h00);
    repeat (3000) @(negedge clk);
    rd(8'h44, 8'h00, "off_ly_rd");
    rd(8'h40, 8'h11, "off_lcdc_rd");
    chk("off_no_vblank", vb_cnt - vs, 0);
    chk("off_no_stat", st_cnt - ss, 0);
    wr(8'h41, 8'h00);

    // re-enable: line 0, dot 0, OAM scan
    wr(8'h40, 8'h91);
    base = cyc;
    v0 = vb_cnt;
    chk("on_dot", dot, 0);
    chk("on_ly", ly, 0);
    chk("on_mode", ppu_mode, 2);
    chk("on_lcd_on", lcd_on, 1);

    goto(0, 79);  chk("m_d79", ppu_mode, 2);
    goto(0, 80);  chk("m_d80", ppu_mode, 3); chk("dot80", dot, 80);
    goto(0, 251); chk("m_d251", ppu_mode, 3);
    goto(0, 252); chk("m_d252", ppu_mode, 0);
    goto(0, 455); chk("m_d455", ppu_mode, 0); chk("dot455", dot, 455);
    goto(1, 0);   chk("wrap_dot", dot, 0); chk("wrap_ly", ly, 1);

    // LYC coincidence interrupt
    goto(1, 10);
    wr(8'h45, 8'h05);
    wr(8'h41, 8'h40);
    s0 = st_cnt;
    goto(5, 0);   chk("lyc_pulse", lcd_stat_irq, 1);
    goto(5, 10);  rd(8'h41, 8'hC6, "lyc_stat_l5a");
    goto(5, 400); rd(8'h41, 8'hC4, "lyc_stat_l5b");
    goto(6, 10);  rd(8'h41, 8'hC2, "lyc_stat_l6");
    goto(6, 20);  chk("lyc_one_pulse", st_cnt - s0, 1);

    // STAT blocking: HBlank hands over to LYC without a low gap
    goto(7, 0);
    wr(8'h41, 8'h48);
    wr(8'h45, 8'h0A);
    goto(9, 1);   s1 = st_cnt;
    goto(9, 252); chk("blk_hblank_pulse", lcd_stat_irq, 1);
    goto(10, 0);  chk("blk_no_pulse", lcd_stat_irq, 0); chk("blk_ly", ly, 10);
    goto(10, 5);  rd(8'h41, 8'hCE, "blk_stat_rd");
    goto(10, 300); chk("blk_one_pulse", st_cnt - s1, 1);
    wr(8'h41, 8'h00);

    // LYC written to match the current line
    goto(20, 100);
    wr(8'h41, 8'h40);
    wr(8'h45, 8'h14);
    chk("lycw_pulse", lcd_stat_irq, 1);
    rd(8'h41, 8'hC7, "lycw_stat_rd");
    wr(8'h41, 8'h00);

    // vblank entry and frame wrap
    goto(143, 455); chk("vb_pre", vblank_irq, 0);
    goto(144, 0);
    chk("vb_pulse", vblank_irq, 1);
    chk("vb_ly", ly, 144);
    chk("vb_dot", dot, 0);
    chk("vb_mode", ppu_mode, 1);
    goto(144, 1);   chk("vb_post", vblank_irq, 0);
    goto(153, 455); chk("l153_mode", ppu_mode, 1); chk("l153_ly", ly, 153);
    goto(154, 0);
    chk("f2_ly", ly, 0);
    chk("f2_dot", dot, 0);
    chk("f2_mode", ppu_mode, 2);
    goto(154, 5);
    chk("vb_count", vb_cnt - v0, 1);
    chk("vb_cycle", vb_last - base, 65664);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
